// File: rtl/bcd_serial_adder.sv
// Digit-serial N-digit BCD adder: latches operands on start, adds one decimal
// digit pair per cycle LSD first, and presents a registered result with a done pulse.
module bcd_serial_adder #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  invalid
);

    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d;
    logic [W-1:0]      work_q, work_d;
    logic [W-1:0]      sum_q, sum_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              winv_q, winv_d;
    logic              cout_q, cout_d;
    logic              inv_q, inv_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [3:0]        a_dig, b_dig, dig;
    logic [4:0]        t;
    logic [5:0]        t_corr;

    // Next-state, digit datapath and result capture
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        winv_d  = winv_q;
        cout_d  = cout_q;
        inv_d   = inv_q;

        a_dig  = a_q[{idx_q, 2'b00} +: 4];
        b_dig  = b_q[{idx_q, 2'b00} +: 4];
        t      = 5'(a_dig) + 5'(b_dig) + 5'(carry_q);
        t_corr = 6'(t) + 6'd6;
        dig    = (t > 5'd9) ? t_corr[3:0] : t[3:0];

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    work_d  = '0;
                    winv_d  = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                work_d[{idx_q, 2'b00} +: 4] = dig;
                carry_d = (t > 5'd9);
                winv_d  = winv_q | (a_dig > 4'd9) | (b_dig > 4'd9);
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == IDXW'(DIGITS - 1)) begin
                    // Publish on the RUN->DONE edge so results line up with done
                    sum_d   = work_d;
                    cout_d  = carry_d;
                    inv_d   = winv_d;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            winv_q  <= 1'b0;
            cout_q  <= 1'b0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            winv_q  <= winv_d;
            cout_q  <= cout_d;
            inv_q   <= inv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign invalid = inv_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4): latency, carry ripple,
// back-to-back start, invalid digits, ignored start and mid-run reset.
module tb_bcd_serial_adder;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a, b;
    logic          cin;
    logic          busy, done, cout, invalid;
    logic [W-1:0]  sum;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] prev_sum;
    logic         prev_cout, prev_inv;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT ready; returns at the negedge of the done cycle.
    // pulse_at >= 0 asserts a spurious start with other operands in that RUN cycle.
    task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input logic [W-1:0] es, input logic ec,
                          input logic ei, input int pulse_at);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            chk({tag, "_hold_sum"}, 32'(sum), 32'(prev_sum));
            chk({tag, "_hold_cout"}, 32'(cout), 32'(prev_cout));
            if (i == pulse_at) begin
                start = 1'b1; a = 16'h9999; b = 16'h9999; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_invalid"}, 32'(invalid), 32'(ei));
        prev_sum = es; prev_cout = ec; prev_inv = ei;
    endtask

    // One idle cycle after a done cycle with start low.
    task automatic idle_step(input string tag);
        @(negedge clk);
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_sum"}, 32'(sum), 32'(prev_sum));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev_sum = '0; prev_cout = 1'b0; prev_inv = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_invalid", 32'(invalid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);

        run_op("basic", 16'h0456, 16'h0123, 1'b0, 16'h0579, 1'b0, 1'b0, -1);
        idle_step("basic");

        run_op("ripple", 16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1, 1'b0, -1);
        idle_step("ripple");

        run_op("cin9999", 16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, -1);
        run_op("b2b", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, -1);
        idle_step("b2b");

        run_op("inval", 16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1, -1);
        idle_step("inval");
        run_op("clr_inv", 16'h0456, 16'h0123, 1'b0, 16'h0579, 1'b0, 1'b0, -1);
        idle_step("clr_inv");

        run_op("ignore", 16'h2500, 16'h2500, 1'b0, 16'h5000, 1'b0, 1'b0, 1);
        idle_step("ignore");
        idle_step("ignore2");

        // Abort mid-run with reset on the second RUN cycle
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy_low", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_invalid", 32'(invalid), 32'd0);
        prev_sum = '0; prev_cout = 1'b0; prev_inv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end

        run_op("after_rst", 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, -1);
        idle_step("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
